// File: rtl/stencil_pipe.sv
// stencil_pipe: 3x3 column-streaming stencil engine (Gaussian blur or Sobel magnitude).
// Columns stream in, a three-column window slides across the frame, and a
// configurable number of lanes computes the centre column's rows over N cycles.
module stencil_pipe #(
    parameter int unsigned ROWS  = 256,
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                data_rdy_in,
    input  logic                last_col_in,
    input  logic [ROWS*W-1:0]   data_in,
    output logic                data_req_out,
    input  logic                data_req_in,
    output logic                data_rdy_out,
    output logic                last_col_out,
    output logic [ROWS*W-1:0]   data_out
);

    localparam int unsigned N  = ROWS / LANES;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {EMPTY, PRIMED, FLUSH, BUSY, HOLD} state_t;
    typedef logic [ROWS-1:0][W-1:0] column_t;

    state_t          state;
    column_t         win_l;
    column_t         win_c;
    column_t         win_r;
    column_t         out_q;
    logic            mode_q;
    logic            last_seen;
    logic            final_col;
    logic [SW-1:0]   s;
    logic [RW-1:0]   lane_row [LANES];
    logic [W-1:0]    lane_px  [LANES];
    logic            in_xfer;
    logic            out_xfer;

    // Neighbour row above (up=1) or below (up=0); rows outside the column read as zero.
    function automatic logic [W-1:0] tap(input column_t col, input logic [RW-1:0] row,
                                         input logic up);
        logic [W-1:0] px;
        px = '0;
        if (up) begin
            if (row != '0) px = col[row - RW'(1)];
        end else begin
            if (row != RW'(ROWS - 1)) px = col[row + RW'(1)];
        end
        return px;
    endfunction

    // One output pixel from the 3x3 neighbourhood (l/c/r columns, t/m/b rows).
    function automatic logic [W-1:0] kernel(input logic sobel,
                                            input logic [W-1:0] lt, input logic [W-1:0] lm,
                                            input logic [W-1:0] lb, input logic [W-1:0] ct,
                                            input logic [W-1:0] cm, input logic [W-1:0] cb,
                                            input logic [W-1:0] rt, input logic [W-1:0] rm,
                                            input logic [W-1:0] rb);
        logic [W+3:0]        sum;
        logic [W+1:0]        wl;
        logic [W+1:0]        wr;
        logic [W+1:0]        wt;
        logic [W+1:0]        wb;
        logic signed [W+2:0] gx;
        logic signed [W+2:0] gy;
        logic [W+2:0]        ax;
        logic [W+2:0]        ay;
        logic [W+3:0]        mag;
        logic [W-1:0]        px;

        sum = (W+4)'(lt) + (W+4)'(rt) + (W+4)'(lb) + (W+4)'(rb)
            + ((W+4)'(ct) << 1) + ((W+4)'(cb) << 1)
            + ((W+4)'(lm) << 1) + ((W+4)'(rm) << 1)
            + ((W+4)'(cm) << 2) + (W+4)'(8);

        wl = (W+2)'(lt) + ((W+2)'(lm) << 1) + (W+2)'(lb);
        wr = (W+2)'(rt) + ((W+2)'(rm) << 1) + (W+2)'(rb);
        wt = (W+2)'(lt) + ((W+2)'(ct) << 1) + (W+2)'(rt);
        wb = (W+2)'(lb) + ((W+2)'(cb) << 1) + (W+2)'(rb);
        gx = $signed({1'b0, wr}) - $signed({1'b0, wl});
        gy = $signed({1'b0, wb}) - $signed({1'b0, wt});
        ax = gx[W+2] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[W+2] ? $unsigned(-gy) : $unsigned(gy);
        mag = (W+4)'(ax) + (W+4)'(ay);

        if (sobel) px = (|mag[W+3:W]) ? '1 : W'(mag);
        else       px = W'(sum >> 4);
        return px;
    endfunction

    // Upstream is accepted while filling, or in HOLD when the output leaves in the same cycle.
    assign data_req_out = (state == EMPTY) || (state == PRIMED) ||
                          ((state == HOLD) && data_req_in && !last_seen && !final_col);
    assign in_xfer  = data_rdy_in && data_req_out;
    assign out_xfer = data_rdy_out && data_req_in;
    assign data_out = out_q;

    // Per-lane row selection and kernel evaluation for the current row step.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_row[l] = RW'(s) * RW'(LANES) + RW'(l);
            lane_px[l]  = kernel(mode_q,
                                 tap(win_l, lane_row[l], 1'b1), win_l[lane_row[l]],
                                 tap(win_l, lane_row[l], 1'b0),
                                 tap(win_c, lane_row[l], 1'b1), win_c[lane_row[l]],
                                 tap(win_c, lane_row[l], 1'b0),
                                 tap(win_r, lane_row[l], 1'b1), win_r[lane_row[l]],
                                 tap(win_r, lane_row[l], 1'b0));
        end
    end

    // Frame control FSM, window shifting and registered output column.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= EMPTY;
            win_l        <= '0;
            win_c        <= '0;
            win_r        <= '0;
            out_q        <= '0;
            mode_q       <= 1'b0;
            last_seen    <= 1'b0;
            final_col    <= 1'b0;
            s            <= '0;
            data_rdy_out <= 1'b0;
            last_col_out <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        win_l  <= win_c;
                        win_c  <= win_r;
                        win_r  <= data_in;
                        mode_q <= mode;
                        state  <= last_col_in ? FLUSH : PRIMED;
                    end
                end
                PRIMED: begin
                    if (in_xfer) begin
                        win_l     <= win_c;
                        win_c     <= win_r;
                        win_r     <= data_in;
                        last_seen <= last_col_in;
                        s         <= '0;
                        state     <= BUSY;
                    end
                end
                FLUSH: begin
                    win_l     <= win_c;
                    win_c     <= win_r;
                    win_r     <= '0;
                    final_col <= 1'b1;
                    s         <= '0;
                    state     <= BUSY;
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        out_q[lane_row[l]] <= lane_px[l];
                    end
                    if (s == SW'(N - 1)) begin
                        data_rdy_out <= 1'b1;
                        last_col_out <= final_col;
                        state        <= HOLD;
                    end else begin
                        s <= s + SW'(1);
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        data_rdy_out <= 1'b0;
                        last_col_out <= 1'b0;
                        if (final_col) begin
                            win_l     <= '0;
                            win_c     <= '0;
                            win_r     <= '0;
                            last_seen <= 1'b0;
                            final_col <= 1'b0;
                            state     <= EMPTY;
                        end else if (last_seen) begin
                            state <= FLUSH;
                        end else if (in_xfer) begin
                            win_l     <= win_c;
                            win_c     <= win_r;
                            win_r     <= data_in;
                            last_seen <= last_col_in;
                            s         <= '0;
                            state     <= BUSY;
                        end else begin
                            state <= PRIMED;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_stencil_pipe.sv
// Scoreboard bench for stencil_pipe: LANES=2 and LANES=4 instances, ROWS=4, W=8.
module tb_stencil_pipe;

    localparam int unsigned ROWS = 4;
    localparam int unsigned W    = 8;

    typedef logic [ROWS*W-1:0] col_t;
    typedef struct {
        col_t data;
        logic last;
    } exp_t;

    logic clock;
    logic reset;
    logic mode;
    logic rdy_in;
    logic last_in;
    logic sel;
    logic req_in;
    col_t din;

    logic rdy_in_a, req_out_a, rdy_out_a, last_out_a;
    logic rdy_in_b, req_out_b, rdy_out_b, last_out_b;
    col_t dout_a, dout_b;
    logic drv_req;

    int   checks;
    int   errors;
    exp_t q_a[$];
    exp_t q_b[$];
    int   img[8][ROWS];

    assign rdy_in_a = rdy_in && !sel;
    assign rdy_in_b = rdy_in && sel;
    assign drv_req  = sel ? req_out_b : req_out_a;

    stencil_pipe #(.ROWS(ROWS), .W(W), .LANES(2)) dut_a (
        .clock(clock), .reset(reset), .mode(mode), .data_rdy_in(rdy_in_a),
        .last_col_in(last_in), .data_in(din), .data_req_out(req_out_a),
        .data_req_in(req_in), .data_rdy_out(rdy_out_a), .last_col_out(last_out_a),
        .data_out(dout_a));

    stencil_pipe #(.ROWS(ROWS), .W(W), .LANES(4)) dut_b (
        .clock(clock), .reset(reset), .mode(mode), .data_rdy_in(rdy_in_b),
        .last_col_in(last_in), .data_in(din), .data_req_out(req_out_b),
        .data_req_in(req_in), .data_rdy_out(rdy_out_b), .last_col_out(last_out_b),
        .data_out(dout_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic col_t mk4(input int a, input int b, input int c, input int d);
        col_t v;
        v = {W'(d), W'(c), W'(b), W'(a)};
        return v;
    endfunction

    function automatic col_t pack_col(input int c);
        col_t v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*W +: W] = W'(img[c][r]);
        return v;
    endfunction

    task automatic set_col(input int c, input int a, input int b, input int d, input int e);
        img[c][0] = a; img[c][1] = b; img[c][2] = d; img[c][3] = e;
    endtask

    // Reference pixel arithmetic over a zero-padded frame of k columns.
    function automatic col_t model_col(input logic sob, input int k, input int c);
        col_t v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            int acc, gx, gy, o;
            acc = 0; gx = 0; gy = 0;
            for (int dc = -1; dc <= 1; dc++) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    int p, wv, wh;
                    p  = 0;
                    if (c + dc >= 0 && c + dc < k && r + dr >= 0 && r + dr < int'(ROWS))
                        p = img[c + dc][r + dr];
                    wv = (dr == 0) ? 2 : 1;
                    wh = (dc == 0) ? 2 : 1;
                    acc += wv * wh * p;
                    gx  += dc * wv * p;
                    gy  += dr * wh * p;
                end
            end
            if (sob) begin
                o = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (o > 255) o = 255;
            end else begin
                o = (acc + 8) / 16;
            end
            v[r*W +: W] = W'(o);
        end
        return v;
    endfunction

    task automatic push_model(input logic to_b, input logic sob, input int k);
        exp_t e;
        for (int c = 0; c < k; c++) begin
            e.data = model_col(sob, k, c);
            e.last = (c == k - 1);
            if (to_b) q_b.push_back(e);
            else      q_a.push_back(e);
        end
    endtask

    task automatic push_hand(input col_t d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        q_a.push_back(e);
    endtask

    // Offer one column; entered just after a rising edge, returns just after the accepting edge.
    task automatic send_col(input col_t d, input logic last);
        int n;
        n = 0;
        din = d; last_in = last; rdy_in = 1'b1;
        @(negedge clock);
        while (!drv_req && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("send_accepted", 64'(drv_req), 64'(1));
        @(posedge clock);
        #1;
        rdy_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic send_frame(input int k);
        for (int c = 0; c < k; c++) send_col(pack_col(c), c == k - 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(name, 64'(q_a.size() + q_b.size()), 64'(0));
        @(posedge clock);
        #1;
    endtask

    // Output monitor: every presented-and-taken column is checked against the queue head.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && rdy_out_a && req_in) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL out_a_unexpected actual=%h last=%b", dout_a, last_out_a);
            end else begin
                e = q_a.pop_front();
                if (dout_a !== e.data || last_out_a !== e.last) begin
                    errors++;
                    $display("FAIL out_a actual=%h last=%b required=%h last=%b",
                             dout_a, last_out_a, e.data, e.last);
                end
            end
        end
        if (!reset && rdy_out_b && req_in) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL out_b_unexpected actual=%h last=%b", dout_b, last_out_b);
            end else begin
                e = q_b.pop_front();
                if (dout_b !== e.data || last_out_b !== e.last) begin
                    errors++;
                    $display("FAIL out_b actual=%h last=%b required=%h last=%b",
                             dout_b, last_out_b, e.data, e.last);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; mode = 1'b0; rdy_in = 1'b0; last_in = 1'b0;
        din = '0; sel = 1'b0; req_in = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_rdy_a",  64'(rdy_out_a),  64'(0));
        chk("rst_last_a", 64'(last_out_a), 64'(0));
        chk("rst_dout_a", 64'(dout_a),     64'(0));
        chk("rst_req_a",  64'(req_out_a),  64'(1));
        chk("rst_rdy_b",  64'(rdy_out_b),  64'(0));
        chk("rst_dout_b", 64'(dout_b),     64'(0));
        chk("rst_req_b",  64'(req_out_b),  64'(1));
        @(posedge clock);
        #1;

        // Blur of a constant 100 image, 3 columns
        for (int c = 0; c < 3; c++) set_col(c, 100, 100, 100, 100);
        mode = 1'b0;
        push_hand(mk4(56, 75, 75, 56), 1'b0);
        push_hand(mk4(75, 100, 100, 75), 1'b0);
        push_hand(mk4(56, 75, 75, 56), 1'b1);
        send_frame(3);
        drain("blur_const_drain");

        // Sobel on columns 0, 255, 255: every pixel saturates
        set_col(0, 0, 0, 0, 0);
        set_col(1, 255, 255, 255, 255);
        set_col(2, 255, 255, 255, 255);
        mode = 1'b1;
        push_hand(mk4(255, 255, 255, 255), 1'b0);
        push_hand(mk4(255, 255, 255, 255), 1'b0);
        push_hand(mk4(255, 255, 255, 255), 1'b1);
        send_frame(3);
        drain("sobel_sat_drain");

        // Single-column frame: FLUSH, 2 BUSY, HOLD with last, then EMPTY
        set_col(0, 10, 20, 30, 40);
        mode = 1'b0;
        push_hand(mk4(5, 10, 15, 14), 1'b1);
        send_col(pack_col(0), 1'b1);
        @(negedge clock);
        chk("single_flush_req", 64'(req_out_a), 64'(0));
        chk("single_flush_rdy", 64'(rdy_out_a), 64'(0));
        @(negedge clock);
        chk("single_busy0_rdy", 64'(rdy_out_a), 64'(0));
        @(negedge clock);
        chk("single_busy1_rdy", 64'(rdy_out_a), 64'(0));
        @(negedge clock);
        chk("single_hold_rdy",  64'(rdy_out_a),  64'(1));
        chk("single_hold_last", 64'(last_out_a), 64'(1));
        chk("single_hold_req",  64'(req_out_a),  64'(0));
        @(negedge clock);
        chk("single_empty_req", 64'(req_out_a), 64'(1));
        chk("single_empty_rdy", 64'(rdy_out_a), 64'(0));
        @(posedge clock);
        #1;

        // Backpressure in HOLD for 10 cycles, then simultaneous in/out transfer
        set_col(0, 12, 40, 7, 99);
        set_col(1, 200, 3, 55, 18);
        set_col(2, 66, 140, 250, 1);
        mode = 1'b0;
        push_model(1'b0, 1'b0, 3);
        req_in = 1'b0;
        send_col(pack_col(0), 1'b0);
        send_col(pack_col(1), 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clock);
            while (!rdy_out_a && n < 20) begin
                @(negedge clock);
                n++;
            end
        end
        chk("bp_hold_reached", 64'(rdy_out_a), 64'(1));
        repeat (10) begin
            @(posedge clock);
            #1 din = col_t'($urandom);
            @(negedge clock);
            if (q_a.size() != 0) chk("bp_dout_stable", 64'(dout_a), 64'(q_a[0].data));
            chk("bp_req_low",  64'(req_out_a),  64'(0));
            chk("bp_rdy_high", 64'(rdy_out_a),  64'(1));
            chk("bp_last_low", 64'(last_out_a), 64'(0));
        end
        @(posedge clock);
        #1;
        din = pack_col(2); last_in = 1'b1; rdy_in = 1'b1; req_in = 1'b1;
        @(negedge clock);
        chk("bp_release_req", 64'(req_out_a), 64'(1));
        @(posedge clock);
        #1 rdy_in = 1'b0; last_in = 1'b0;
        @(negedge clock);
        chk("bp_busy0_rdy", 64'(rdy_out_a), 64'(0));
        @(negedge clock);
        chk("bp_busy1_rdy", 64'(rdy_out_a), 64'(0));
        @(negedge clock);
        chk("bp_rdy_again", 64'(rdy_out_a), 64'(1));
        @(posedge clock);
        #1;
        drain("bp_drain");

        // Reset asserted while BUSY at s=1 aborts the frame
        set_col(0, 90, 91, 92, 93);
        set_col(1, 1, 2, 3, 4);
        mode = 1'b0;
        send_col(pack_col(0), 1'b0);
        send_col(pack_col(1), 1'b0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_rdy",  64'(rdy_out_a),  64'(0));
        chk("midrst_last", 64'(last_out_a), 64'(0));
        chk("midrst_dout", 64'(dout_a),     64'(0));
        chk("midrst_req",  64'(req_out_a),  64'(1));
        @(posedge clock);
        #1;
        set_col(0, 5, 60, 120, 240);
        set_col(1, 0, 90, 30, 200);
        set_col(2, 255, 10, 70, 35);
        mode = 1'b1;
        push_model(1'b0, 1'b1, 3);
        send_frame(3);
        drain("midrst_frame_drain");

        // Vertical edge, Sobel, on LANES=2 and then LANES=4
        set_col(0, 0, 0, 0, 0);
        set_col(1, 0, 0, 0, 0);
        set_col(2, 200, 200, 200, 200);
        set_col(3, 200, 200, 200, 200);
        mode = 1'b1;
        push_model(1'b0, 1'b1, 4);
        send_frame(4);
        drain("edge_l2_drain");
        sel = 1'b1;
        push_model(1'b1, 1'b1, 4);
        send_col(pack_col(0), 1'b0);
        send_col(pack_col(1), 1'b0);
        @(negedge clock);
        chk("l4_busy_rdy", 64'(rdy_out_b), 64'(0));
        @(negedge clock);
        chk("l4_hold_rdy", 64'(rdy_out_b), 64'(1));
        @(posedge clock);
        #1;
        send_col(pack_col(2), 1'b0);
        send_col(pack_col(3), 1'b1);
        drain("edge_l4_drain");
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stencil_pipe.md
# stencil_pipe

Parametrised 3x3 column-streaming stencil engine for the image pipeline. It sits between the greyscale stage and the downstream consumer, replacing the fixed blur and gradient pipes. It accepts one image column of ROWS pixels per transfer and emits one filtered column per input column. A runtime mode selects Gaussian blur or Sobel magnitude. A configurable number of arithmetic lanes time-multiplexes the rows, trading area for latency.

## Interface
- ROWS, 256: pixels per column; must be a multiple of LANES.
- W, 8: pixel width in bits, input and output.
- LANES, 256: parallel kernel units; N = ROWS/LANES is the number of compute cycles per column.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clock.
- mode  in  1  0 = blur, 1 = Sobel magnitude; latched on the first column of a frame.
- data_rdy_in  in  1  upstream column valid.
- last_col_in  in  1  qualifies data_in as the final column of the frame.
- data_in  in  ROWS*W  packed column; [r] is row r.
- data_req_out  out  1  block accepts a column this cycle.
- data_req_in  in  1  downstream accepts the output column this cycle.
- data_rdy_out  out  1  data_out holds a valid column.
- last_col_out  out  1  qualifies data_out as the final output column.
- data_out  out  ROWS*W  filtered column, registered.

## Operation
- An input transfer occurs when data_rdy_in && data_req_out. An output transfer occurs when data_rdy_out && data_req_in.
- The window has three column registers L, C, R. A shift moves C to L, R to C, and new data to R.
- Padding: rows -1 and ROWS are 0; a virtual zero column precedes the first column and follows the last.
- The window is never read while a shift is pending.
- FSM states: EMPTY, PRIMED, FLUSH, BUSY, HOLD.
- EMPTY:
  - window is all zero; data_req_out = 1.
  - on transfer: shift in and latch mode.
  - if last_col_in, go to FLUSH; else go to PRIMED.
- PRIMED:
  - data_req_out = 1.
  - on transfer: shift in, set last_seen <= last_col_in, go to BUSY.
- FLUSH:
  - shift in a zero column, set final <= 1, go to BUSY.
  - takes exactly one cycle; data_req_out = 0.
- BUSY:
  - row counter s runs 0..N-1.
  - each cycle, lane l computes row r = s*LANES + l and writes data_out[r].
  - after s = N-1, go to HOLD.
- HOLD:
  - data_rdy_out = 1 and last_col_out = final.
  - data_req_out = data_req_in && !last_seen && !final.
  - On output transfer:
    - if final: clear the window, last_seen and final, go to EMPTY.
    - else if last_seen: go to FLUSH.
    - else if an input transfer happens in the same cycle: shift in, set last_seen <= last_col_in, go to BUSY.
    - else: go to PRIMED, keeping the window.
- Blur:
  - S = sum of the neighbourhood with weights 1 2 1 / 2 4 2 / 1 2 1, held in W+4 bits.
  - out = (S + 8) >> 4, which never exceeds 2^W-1.
- Sobel:
  - gx = (R weighted 1,2,1 over rows r-1,r,r+1) - (L weighted the same way).
  - gy = (row r+1 weighted 1,2,1 over L,C,R) - (row r-1 weighted the same way).
  - gx and gy are signed, W+3 bits.
  - out = min(|gx| + |gy|, 2^W-1).
- Reset values:
  - state = EMPTY; window, data_out, last_seen and final are all 0.
  - data_rdy_out = 0; last_col_out = 0; data_req_out = 1 in the cycle after reset deasserts.
- Reset asserted in any state, including mid-BUSY, aborts the frame. No partial column is ever presented.
- A frame of K columns produces exactly K output columns. Only the K-th output column has last_col_out = 1.

## Timing
- Input transfer on edge E0 in PRIMED or HOLD: the next N edges are BUSY, and data_rdy_out = 1 in the cycle after edge E0+N.
- First column of a frame: no output is produced. The output for column c starts after column c+1 is accepted or after FLUSH.
- Final column: output transfer, then 1 FLUSH cycle, then N BUSY cycles, then HOLD with last_col_out = 1.
- With LANES = ROWS and no stalls, throughput is 1 column per 2 cycles (HOLD, then 1 BUSY cycle).
- data_out and last_col_out are stable throughout HOLD, independent of data_in and data_rdy_in.
- data_req_out is combinational from state, data_req_in and flags.

## Test plan
All scenarios use ROWS=4, LANES=2, W=8 unless stated.
- Blur, constant image of 3 columns, every pixel 100:
  - centre-column interior rows 1 and 2 = 100.
  - corner pixel (row 0, col 0) = (9*100 + 8) >> 4 = 56.
  - 3 outputs, last_col_out only on the third.
- Sobel, 3 columns [0, 255, 255], all rows:
  - column 1, row 1: gx = 1020, saturates to 255.
  - column 2 rows 1 and 2: gx = 0 - 4*255, |gy| = 0, saturates to 255.
- Single-column frame (last_col_in on the first transfer):
  - sequence is FLUSH, then 2 BUSY cycles, then HOLD with last_col_out = 1.
  - then EMPTY with data_req_out = 1.
- Backpressure: hold data_req_in = 0 for 10 cycles in HOLD.
  - data_out is unchanged and data_req_out = 0.
  - on release with data_rdy_in = 1: input and output transfer in the same cycle, data_rdy_out = 1 again 2 cycles later.
- Reset mid-BUSY (s = 1):
  - next cycle: state EMPTY, data_out = 0, data_rdy_out = 0.
  - a new 3-column frame then yields correct results.
- LANES=4 variant: a vertical edge image gives bit-identical data_out to the LANES=2 run, with the BUSY phase lasting 1 cycle.
